// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multi-cycle MIPS core: opcodes, functs, ALU ops,
// FSM states and small decode helpers.
package mips_mc_pkg;

   localparam logic [31:0] IO_ADDR_DEFAULT = 32'hFFFF_0000;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL = 6'h00;
   localparam logic [5:0] FN_SRL = 6'h02;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_NOR = 6'h27;

   typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WB, HALT} mcState;

   typedef enum logic [2:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR, ALU_SLL, ALU_SRL, ALU_LUI
   } aluOp;

   function automatic logic isLegal(input logic [5:0] opcode, input logic [5:0] funct);
      logic ok;
      ok = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLL, FN_SRL: ok = 1'b1;
               default: ok = 1'b0;
            endcase
         end
         OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW: ok = 1'b1;
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic aluOp aluOpFor(input logic [5:0] opcode, input logic [5:0] funct);
      aluOp op;
      op = ALU_ADD;
      if (opcode == OP_RTYPE) begin
         case (funct)
            FN_SUB:  op = ALU_SUB;
            FN_AND:  op = ALU_AND;
            FN_OR:   op = ALU_OR;
            FN_NOR:  op = ALU_NOR;
            FN_SLL:  op = ALU_SLL;
            FN_SRL:  op = ALU_SRL;
            default: op = ALU_ADD;
         endcase
      end else begin
         case (opcode)
            OP_ANDI: op = ALU_AND;
            OP_ORI:  op = ALU_OR;
            OP_LUI:  op = ALU_LUI;
            default: op = ALU_ADD;
         endcase
      end
      return op;
   endfunction

endpackage

// File: rtl/mips_mc_if.sv
// Shared instruction/data memory port with a valid/ready handshake.
interface mips_mc_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;

   modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ready);
   modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ready);
endinterface

// File: rtl/mips_mc_control.sv
// Control FSM for the multi-cycle core: sequences FETCH/DECODE/EXECUTE/MEM/WB
// and drives datapath load enables plus the memory handshake.
module mips_mc_control
   import mips_mc_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       memReady,
   input  logic       branchTaken,
   input  logic       addrMisaligned,
   input  logic       ioHit,
   output logic       irLoad,
   output logic       pcIncLoad,
   output logic       pcTargetLoad,
   output logic       pcJumpLoad,
   output logic       abLoad,
   output logic       aluOutLoad,
   output logic       aluResultLoad,
   output logic       mdrLoad,
   output logic       mdrFromIo,
   output logic       portOutLoad,
   output logic       regWrite,
   output logic       addrSelData,
   output logic       memReq,
   output logic       memWe,
   output logic       instrDone,
   output logic       halted
);

   mcState stateReg, stateNext;

   always_ff @(posedge clk) begin
      if (reset) stateReg <= FETCH;
      else       stateReg <= stateNext;
   end

   always_comb begin
      stateNext     = stateReg;
      irLoad        = 1'b0;
      pcIncLoad     = 1'b0;
      pcTargetLoad  = 1'b0;
      pcJumpLoad    = 1'b0;
      abLoad        = 1'b0;
      aluOutLoad    = 1'b0;
      aluResultLoad = 1'b0;
      mdrLoad       = 1'b0;
      mdrFromIo     = 1'b0;
      portOutLoad   = 1'b0;
      regWrite      = 1'b0;
      addrSelData   = 1'b0;
      memReq        = 1'b0;
      memWe         = 1'b0;
      instrDone     = 1'b0;
      halted        = 1'b0;

      case (stateReg)
         FETCH: begin
            memReq = 1'b1;
            if (memReady) begin
               irLoad    = 1'b1;
               pcIncLoad = 1'b1;
               stateNext = DECODE;
            end
         end
         DECODE: begin
            abLoad    = 1'b1;
            stateNext = isLegal(opcode, funct) ? EXECUTE : HALT;
         end
         EXECUTE: begin
            case (opcode)
               OP_BEQ, OP_BNE: begin
                  pcTargetLoad = branchTaken;
                  instrDone    = 1'b1;
                  stateNext    = FETCH;
               end
               OP_J: begin
                  pcJumpLoad = 1'b1;
                  instrDone  = 1'b1;
                  stateNext  = FETCH;
               end
               OP_LW, OP_SW: begin
                  aluOutLoad = 1'b1;
                  stateNext  = addrMisaligned ? HALT : MEM;
               end
               default: begin
                  aluOutLoad    = 1'b1;
                  aluResultLoad = 1'b1;
                  stateNext     = WB;
               end
            endcase
         end
         MEM: begin
            addrSelData = 1'b1;
            // The IO word is served internally in one cycle without touching the bus.
            if (ioHit) begin
               if (opcode == OP_LW) begin
                  mdrLoad   = 1'b1;
                  mdrFromIo = 1'b1;
                  stateNext = WB;
               end else begin
                  portOutLoad = 1'b1;
                  instrDone   = 1'b1;
                  stateNext   = FETCH;
               end
            end else begin
               memReq = 1'b1;
               memWe  = (opcode == OP_SW);
               if (memReady) begin
                  if (opcode == OP_LW) begin
                     mdrLoad   = 1'b1;
                     stateNext = WB;
                  end else begin
                     instrDone = 1'b1;
                     stateNext = FETCH;
                  end
               end
            end
         end
         WB: begin
            regWrite  = 1'b1;
            instrDone = 1'b1;
            stateNext = FETCH;
         end
         HALT: begin
            halted = 1'b1;
         end
         default: stateNext = FETCH;
      endcase

      // Reset abandons any in-flight access immediately.
      if (reset) begin
         memReq    = 1'b0;
         memWe     = 1'b0;
         instrDone = 1'b0;
         halted    = 1'b0;
      end
   end

endmodule

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS core top: datapath, register file and ALU around the
// control FSM, sharing one memory port for fetch and data.
module mips_multicycle_core
   import mips_mc_pkg::*;
#(
   parameter logic [31:0] PC_RESET       = 32'h0000_0000,
   parameter logic [31:0] IO_ADDR        = IO_ADDR_DEFAULT,
   parameter int          PORT_IN_WIDTH  = 8,
   parameter int          PORT_OUT_WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   mips_mc_if.master                 mem,
   input  logic [PORT_IN_WIDTH-1:0]  PortIn,
   output logic [PORT_OUT_WIDTH-1:0] PortOut,
   output logic [31:0]               ALUResultOut,
   output logic                      instr_done,
   output logic                      halted
);

   logic [31:0] pcReg, irReg, aReg, bReg, aluOutReg, mdrReg, targetReg, aluResultReg;
   logic [PORT_OUT_WIDTH-1:0] portOutReg;
   logic [31:0] regFile [32];
   logic [31:0] regWe;

   logic irLoad, pcIncLoad, pcTargetLoad, pcJumpLoad, abLoad, aluOutLoad, aluResultLoad;
   logic mdrLoad, mdrFromIo, portOutLoad, regWrite, addrSelData, memReq, memWe;
   logic instrDone, haltedCtl;

   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd, shamt, writeAddr;
   logic [15:0] imm;
   logic [31:0] immSext, immZext, aluB, aluResult, writeData;
   logic        aEqB, branchTaken, addrMisaligned, ioHit;
   aluOp        aluSel;

   assign opcode  = irReg[31:26];
   assign rs      = irReg[25:21];
   assign rt      = irReg[20:16];
   assign rd      = irReg[15:11];
   assign shamt   = irReg[10:6];
   assign funct   = irReg[5:0];
   assign imm     = irReg[15:0];
   assign immSext = {{16{imm[15]}}, imm};
   assign immZext = {16'h0000, imm};

   assign aEqB           = (aReg == bReg);
   assign branchTaken    = (opcode == OP_BNE) ? !aEqB : aEqB;
   assign addrMisaligned = (aluResult[1:0] != 2'b00);
   assign ioHit          = (aluOutReg == IO_ADDR);

   mips_mc_control u_control (
      .clk            (clk),
      .reset          (reset),
      .opcode         (opcode),
      .funct          (funct),
      .memReady       (mem.mem_ready),
      .branchTaken    (branchTaken),
      .addrMisaligned (addrMisaligned),
      .ioHit          (ioHit),
      .irLoad         (irLoad),
      .pcIncLoad      (pcIncLoad),
      .pcTargetLoad   (pcTargetLoad),
      .pcJumpLoad     (pcJumpLoad),
      .abLoad         (abLoad),
      .aluOutLoad     (aluOutLoad),
      .aluResultLoad  (aluResultLoad),
      .mdrLoad        (mdrLoad),
      .mdrFromIo      (mdrFromIo),
      .portOutLoad    (portOutLoad),
      .regWrite       (regWrite),
      .addrSelData    (addrSelData),
      .memReq         (memReq),
      .memWe          (memWe),
      .instrDone      (instrDone),
      .halted         (haltedCtl)
   );

   assign mem.mem_req   = memReq;
   assign mem.mem_we    = memWe;
   assign mem.mem_addr  = addrSelData ? aluOutReg : pcReg;
   assign mem.mem_wdata = bReg;

   assign PortOut      = portOutReg;
   assign ALUResultOut = aluResultReg;
   assign instr_done   = instrDone;
   assign halted       = haltedCtl;

   always_comb begin
      aluSel    = aluOpFor(opcode, funct);
      aluB      = immSext;
      aluResult = '0;
      if (opcode == OP_RTYPE)
         aluB = bReg;
      else if (opcode == OP_ANDI || opcode == OP_ORI || opcode == OP_LUI)
         aluB = immZext;
      case (aluSel)
         ALU_ADD: aluResult = aReg + aluB;
         ALU_SUB: aluResult = aReg - aluB;
         ALU_AND: aluResult = aReg & aluB;
         ALU_OR:  aluResult = aReg | aluB;
         ALU_NOR: aluResult = ~(aReg | aluB);
         ALU_SLL: aluResult = bReg << shamt;
         ALU_SRL: aluResult = bReg >> shamt;
         ALU_LUI: aluResult = {aluB[15:0], 16'h0000};
         default: aluResult = aReg + aluB;
      endcase
   end

   // R-type writes rd; I-type ALU ops and lw write rt.
   assign writeAddr = (opcode == OP_RTYPE) ? rd : rt;
   assign writeData = (opcode == OP_LW) ? mdrReg : aluOutReg;

   for (genvar gi = 0; gi < 32; gi++) begin : gRegWe
      if (gi == 0) begin : gZero
         assign regWe[gi] = 1'b0;
      end else begin : gWr
         assign regWe[gi] = regWrite && (writeAddr == 5'(gi));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) regFile[i] <= '0;
      end else begin
         for (int i = 1; i < 32; i++) begin
            if (regWe[i]) regFile[i] <= writeData;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pcReg        <= PC_RESET;
         irReg        <= '0;
         aReg         <= '0;
         bReg         <= '0;
         targetReg    <= '0;
         aluOutReg    <= '0;
         aluResultReg <= '0;
         mdrReg       <= '0;
         portOutReg   <= '0;
      end else begin
         if (irLoad) irReg <= mem.mem_rdata;
         if (pcIncLoad)
            pcReg <= pcReg + 32'd4;
         else if (pcTargetLoad)
            pcReg <= targetReg;
         else if (pcJumpLoad)
            pcReg <= {pcReg[31:28], irReg[25:0], 2'b00};
         // pcReg already points past the branch here, so the target is PC+4+offset.
         if (abLoad) begin
            aReg      <= regFile[rs];
            bReg      <= regFile[rt];
            targetReg <= pcReg + (immSext << 2);
         end
         if (aluOutLoad)    aluOutReg    <= aluResult;
         if (aluResultLoad) aluResultReg <= aluResult;
         if (mdrLoad)       mdrReg       <= mdrFromIo ? 32'(PortIn) : mem.mem_rdata;
         if (portOutLoad)   portOutReg   <= bReg[PORT_OUT_WIDTH-1:0];
      end
   end

endmodule

// File: doc/mips_multicycle_core.md
Name: mips_multicycle_core

Overview:
- Multi-cycle MIPS core. Each instruction runs through a control FSM and shares one memory port for instruction fetch and data access.
- A valid/ready handshake on that port lets memory insert wait states.
- Adds capabilities the single-cycle core lacks:
  - taken branches and jumps
  - lw/sw
  - memory-mapped PortIn/PortOut
  - halt on illegal instruction.
- Sits at the processor top level, between the board memory/IO wrapper and the register file/ALU datapath.

Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded at reset.
- IO_ADDR, 32'hFFFF_0000, byte address of the IO word. Reads return PortIn zero-extended; writes update PortOut.
- PORT_IN_WIDTH, 8, width of PortIn.
- PORT_OUT_WIDTH, 32, width of PortOut.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high.
- mem_req  out  1  memory access valid.
- mem_we  out  1  1 = write, 0 = read; meaningful only while mem_req=1.
- mem_addr  out  32  byte address, word aligned.
- mem_wdata  out  32  store data.
- mem_rdata  in  32  read data; valid in the cycle mem_ready=1.
- mem_ready  in  1  completes the access in the cycle it is sampled with mem_req=1.
- PortIn  in  PORT_IN_WIDTH  input port.
- PortOut  out  PORT_OUT_WIDTH  registered output port.
- ALUResultOut  out  32  registered result of the last EXECUTE.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- halted  out  1  set on an illegal opcode/funct or a misaligned lw/sw.

Behaviour:
- Reset values (synchronous reset wins over every other event in that cycle):
  - PC=PC_RESET; state=FETCH.
  - mem_req=0 during the reset cycle; FETCH asserts it from the first cycle after reset deasserts.
  - PortOut=0, ALUResultOut=0, instr_done=0, halted=0.
  - Register file cleared; $0 always reads 0 and writes to it are discarded.
- Supported instructions: add, sub, and, or, nor, sll, srl (using shamt), addi, andi, ori, lui, lw, sw, beq, bne, j.
  - addi, lw and sw sign-extend the immediate.
  - andi and ori zero-extend it.
  - lui writes {imm,16'h0}.
  - Overflow is ignored (no trap).
- FETCH:
  - mem_req=1, mem_we=0, mem_addr=PC.
  - Hold in FETCH until mem_ready=1, then IR<=mem_rdata, PC<=PC+4, go to DECODE.
- DECODE:
  - Latch A=rs and B=rt; compute branch target PC+4+(sext(imm)<<2).
  - Illegal op/funct: go to HALT.
- EXECUTE:
  - R/I ALU ops: ALUOut<=result, ALUResultOut<=result, go to WB.
  - beq/bne: if taken, PC<=target; retire; go to FETCH.
  - j: PC<={PC[31:28],IR[25:0],2'b00}; retire; go to FETCH.
  - lw/sw: compute the address. If addr[1:0]!=0, go to HALT; otherwise go to MEM.
- MEM:
  - Address == IO_ADDR: no mem_req; takes one cycle.
    - lw loads {0,PortIn} into MDR and goes to WB.
    - sw sets PortOut<=B[PORT_OUT_WIDTH-1:0] and retires.
  - Any other address: mem_req=1 with mem_we=sw. Hold until mem_ready=1.
    - lw latches MDR and goes to WB.
    - sw retires.
- WB:
  - Write to rd (R-type) or rt (I-type, lw); retire; go to FETCH.
- Request stability: while mem_req=1 and mem_ready=0, mem_addr, mem_we and mem_wdata hold stable. mem_req never drops before completion except on reset.
- instr_done pulses for one cycle in the retiring cycle.
- Latency with mem_ready tied to 1:
  - ALU ops 4 cycles.
  - lw 5 cycles.
  - sw, beq, bne and j 3 or 4 cycles (beq/bne/j 3, sw 4).
  - Each wait cycle adds 1.
- HALT:
  - halted=1 and stays high; no further memory requests.
  - PC stays at the faulting instruction address + 4.
  - Only reset leaves HALT.
- Reset mid-access: the request is abandoned with no handshake completion. mem_req is 0 during the reset cycle and the first cycle after reset is FETCH at PC_RESET.

Decomposition:
- Shared package mips_mc_pkg holds:
  - opcode and funct constants
  - ALU operation codes
  - the FSM state enum (FETCH, DECODE, EXECUTE, MEM, WB, HALT)
  - the IO_ADDR default.
- One sub-module, mips_mc_control: the FSM. It produces the IR/PC/A/B/MDR load enables, mem_req, mem_we and instr_done from state, opcode, funct, mem_ready and the address checks.
- The datapath, register file and ALU stay in the top module.

Test Plan:
- Reset, then program "addi $1,$0,5; addi $2,$0,7; add $3,$1,$2" with mem_ready=1 -> $3=12, ALUResultOut=12, three instr_done pulses 4 cycles apart.
- mem_ready held low 3 cycles during the fetch of the first instruction -> mem_addr=0 stable throughout, instruction retires at cycle 7 instead of 4.
- "beq $0,$0,+2" at PC 0x8 -> next fetch address 0x14. "bne $0,$0,+2" -> next fetch 0xC. "j 0x10" -> next fetch 0x40.
- sw of 0xA5 to IO_ADDR -> PortOut=0xA5 with no mem_req. With PortIn=0x3C, lw from IO_ADDR -> rt=0x0000_003C.
- lw from 0x102 -> halted=1, mem_req stays 0 thereafter. A following reset -> halted=0, fetch from PC_RESET.
- Reset asserted during a pending sw with mem_ready=0 -> mem_req=0 during the reset cycle, PortOut=0, next fetch address PC_RESET.
